// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for the mem_port_arbiter slice.
//   owner_t      - identifies a requester (0 = p0, 1 = p1)
//   arb_state_t  - arbiter lock state
//   mem_req_t    - request payload, muxed as one unit onto the MMU port
// Optional build macro used by this slice: MEM_ARB_FIXED_PRIO_EN.
package mem_arb_pkg;

    typedef logic owner_t;

    localparam int unsigned MAX_OUTSTANDING_DEF = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the two LSU request ports and the MMU
// data-side port (req/addr_ok/data_ok split-transaction protocol).
//   modport master - arbiter view: takes LSU requests, drives the MMU request
//                    and the per-requester addr_ok/data_ok/rdata
//   modport slave  - environment view: LSUs plus the MMU
interface mem_port_arbiter_if;

    logic        p0_req;
    logic [31:0] p0_addr;
    logic        p0_we;
    logic [1:0]  p0_size;
    logic [3:0]  p0_wstrb;
    logic [31:0] p0_wdata;
    logic        p0_addr_ok;
    logic        p0_data_ok;

    logic        p1_req;
    logic [31:0] p1_addr;
    logic        p1_we;
    logic [1:0]  p1_size;
    logic [3:0]  p1_wstrb;
    logic [31:0] p1_wdata;
    logic        p1_addr_ok;
    logic        p1_data_ok;

    logic [31:0] rdata;

    logic        mmu_req;
    logic [31:0] mmu_addr;
    logic        mmu_we;
    logic [1:0]  mmu_size;
    logic [3:0]  mmu_wstrb;
    logic [31:0] mmu_wdata;
    logic        mmu_addr_ok;
    logic        mmu_data_ok;
    logic [31:0] mmu_rdata;

    modport master (
        input  p0_req, p0_addr, p0_we, p0_size, p0_wstrb, p0_wdata,
        output p0_addr_ok, p0_data_ok,
        input  p1_req, p1_addr, p1_we, p1_size, p1_wstrb, p1_wdata,
        output p1_addr_ok, p1_data_ok,
        output rdata,
        output mmu_req, mmu_addr, mmu_we, mmu_size, mmu_wstrb, mmu_wdata,
        input  mmu_addr_ok, mmu_data_ok, mmu_rdata
    );

    modport slave (
        output p0_req, p0_addr, p0_we, p0_size, p0_wstrb, p0_wdata,
        input  p0_addr_ok, p0_data_ok,
        output p1_req, p1_addr, p1_we, p1_size, p1_wstrb, p1_wdata,
        input  p1_addr_ok, p1_data_ok,
        input  rdata,
        input  mmu_req, mmu_addr, mmu_we, mmu_size, mmu_wstrb, mmu_wdata,
        output mmu_addr_ok, mmu_data_ok, mmu_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_owner_fifo.sv
// owner_fifo: in-order record of which requester owns each request the MMU
// has accepted but not yet answered.
//   clk, reset  - clock, synchronous active-high reset
//   push, din   - record a new owner (honoured when full only if popping too)
//   pop         - retire the head entry (ignored when empty)
//   head        - owner of the oldest outstanding request
//   full, empty, count - occupancy, count is $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  owner_t                 din,
    input  logic                   pop,
    output owner_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    owner_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the MMU data-side request port between two LSU
// requesters. One requester is granted per address handshake; the owner of
// each accepted request is queued in order and the returning data_ok is
// steered back to it with zero added latency.
//   clk, reset      - clock, synchronous active-high reset
//   bus (master)    - p0/p1 request ports, MMU port, broadcast rdata
// Parameter MAX_OUTSTANDING (power of two >= 2): accepted requests that may
// await data_ok.
// Build macro MEM_ARB_FIXED_PRIO_EN: p0 always wins idle arbitration and the
// round-robin pointer is removed; lock behaviour is unchanged.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    arb_state_t state;
    owner_t     lock_owner;
`ifndef MEM_ARB_FIXED_PRIO_EN
    owner_t     rr_ptr;
`endif

    owner_t   gnt;
    logic     gnt_req;
    logic     pop;
    logic     handshake;
    mem_req_t p0_pl;
    mem_req_t p1_pl;
    mem_req_t sel_pl;

    owner_t                            fifo_head;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic [$clog2(MAX_OUTSTANDING):0]  fifo_count;

    // Grant: a locked owner keeps the port; otherwise a lone requester wins,
    // and a tie goes to rr_ptr (or p0 with fixed priority).
    always_comb begin
        gnt = 1'b0;
        if (state == ARB_LOCKED) begin
            gnt = lock_owner;
        end else if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt = 1'b0;
`else
            gnt = rr_ptr;
`endif
        end else begin
            gnt = bus.p1_req;
        end
    end

    always_comb begin
        p0_pl  = '{addr: bus.p0_addr, we: bus.p0_we, size: bus.p0_size,
                   wstrb: bus.p0_wstrb, wdata: bus.p0_wdata};
        p1_pl  = '{addr: bus.p1_addr, we: bus.p1_we, size: bus.p1_size,
                   wstrb: bus.p1_wstrb, wdata: bus.p1_wdata};
        sel_pl = gnt ? p1_pl : p0_pl;
    end

    assign gnt_req   = gnt ? bus.p1_req : bus.p0_req;
    assign pop       = bus.mmu_data_ok && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO need not stall.
    assign bus.mmu_req   = gnt_req && (!fifo_full || pop);
    assign handshake     = bus.mmu_req && bus.mmu_addr_ok;

    assign bus.mmu_addr  = sel_pl.addr;
    assign bus.mmu_we    = sel_pl.we;
    assign bus.mmu_size  = sel_pl.size;
    assign bus.mmu_wstrb = sel_pl.wstrb;
    assign bus.mmu_wdata = sel_pl.wdata;

    assign bus.p0_addr_ok = handshake && (gnt == 1'b0);
    assign bus.p1_addr_ok = handshake && (gnt == 1'b1);
    assign bus.p0_data_ok = pop && (fifo_head == 1'b0);
    assign bus.p1_data_ok = pop && (fifo_head == 1'b1);
    assign bus.rdata      = bus.mmu_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            lock_owner <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    // Lock also while stalled on a full FIFO.
                    if (gnt_req && !handshake) begin
                        state      <= ARB_LOCKED;
                        lock_owner <= gnt;
                    end
                end
                ARB_LOCKED: begin
                    if (!gnt_req || handshake) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
`ifndef MEM_ARB_FIXED_PRIO_EN
            if (handshake) begin
                rr_ptr <= ~gnt;
            end
`endif
        end
    end

    owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (handshake),
        .din   (gnt),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && bus.mmu_data_ok) begin
            assert (fifo_count != '0)
                else $error("mmu_data_ok with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic for
// mem_port_arbiter, checked every cycle against a queue-based reference
// model of the arbitration and response-routing rules.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned MAXO = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // stimulus
    logic        rq [2];
    mem_req_t    pl [2];
    logic        aok;
    logic        dok;
    logic [31:0] rd;

    // reference model state
    int q[$];
    bit locked;
    int lk_own;
    int rr;

    // predictions for the current cycle
    int e_gnt;
    bit e_mreq;
    bit e_pop;
    bit e_aok [2];
    bit e_dok [2];

    // observations of the current cycle
    logic        obs_mreq;
    logic        obs_aok [2];
    logic        obs_dok [2];
    logic [31:0] obs_addr;
    logic [31:0] obs_rdata;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_t rand_pl();
        mem_req_t r;
        r.addr  = $urandom;
        r.we    = 1'($urandom_range(0, 1));
        r.size  = 2'($urandom_range(0, 2));
        r.wstrb = 4'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic drive();
        bus.p0_req      = rq[0];
        bus.p0_addr     = pl[0].addr;
        bus.p0_we       = pl[0].we;
        bus.p0_size     = pl[0].size;
        bus.p0_wstrb    = pl[0].wstrb;
        bus.p0_wdata    = pl[0].wdata;
        bus.p1_req      = rq[1];
        bus.p1_addr     = pl[1].addr;
        bus.p1_we       = pl[1].we;
        bus.p1_size     = pl[1].size;
        bus.p1_wstrb    = pl[1].wstrb;
        bus.p1_wdata    = pl[1].wdata;
        bus.mmu_addr_ok = aok;
        bus.mmu_data_ok = dok;
        bus.mmu_rdata   = rd;
    endtask

    // Who gets the port, whether the MMU sees a request, who gets data back.
    function automatic void predict();
        if (locked)                 e_gnt = lk_own;
        else if (rq[0] && rq[1])    e_gnt = FIXED ? 0 : rr;
        else if (rq[1])             e_gnt = 1;
        else                        e_gnt = 0;
        e_pop  = dok && (q.size() > 0);
        e_mreq = rq[e_gnt] && ((q.size() < MAXO) || e_pop);
        for (int x = 0; x < 2; x++) begin
            e_aok[x] = aok && e_mreq && (e_gnt == x);
            e_dok[x] = e_pop && (q[0] == x);
        end
    endfunction

    // One clock cycle: inputs are already set; check mid-cycle, advance model.
    task automatic step();
        logic [31:0] exp_ctl;
        logic [31:0] obs_ctl;
        drive();
        #3;
        predict();
        obs_mreq   = bus.mmu_req;
        obs_aok[0] = bus.p0_addr_ok;
        obs_aok[1] = bus.p1_addr_ok;
        obs_dok[0] = bus.p0_data_ok;
        obs_dok[1] = bus.p1_data_ok;
        obs_addr   = bus.mmu_addr;
        obs_rdata  = bus.rdata;
        chk("mmu_req", 32'(obs_mreq), 32'(e_mreq));
        chk("p0_addr_ok", 32'(obs_aok[0]), 32'(e_aok[0]));
        chk("p1_addr_ok", 32'(obs_aok[1]), 32'(e_aok[1]));
        chk("p0_data_ok", 32'(obs_dok[0]), 32'(e_dok[0]));
        chk("p1_data_ok", 32'(obs_dok[1]), 32'(e_dok[1]));
        chk("rdata", obs_rdata, rd);
        if (e_mreq) begin
            exp_ctl = {25'd0, pl[e_gnt].we, pl[e_gnt].size, pl[e_gnt].wstrb};
            obs_ctl = {25'd0, bus.mmu_we, bus.mmu_size, bus.mmu_wstrb};
            chk("mmu_addr", obs_addr, pl[e_gnt].addr);
            chk("mmu_ctl", obs_ctl, exp_ctl);
            chk("mmu_wdata", bus.mmu_wdata, pl[e_gnt].wdata);
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            locked = 1'b0;
            rr     = 0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_mreq && aok) begin
                q.push_back(e_gnt);
                rr = 1 - e_gnt;
            end
            if (rq[e_gnt] && !(e_mreq && aok)) begin
                locked = 1'b1;
                lk_own = e_gnt;
            end else begin
                locked = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        bit exp_p1;
        total  = 0;
        bad    = 0;
        rq     = '{1'b0, 1'b0};
        pl[0]  = rand_pl();
        pl[1]  = rand_pl();
        aok    = 1'b0;
        dok    = 1'b0;
        rd     = $urandom;
        reset  = 1'b1;
        locked = 1'b0;
        lk_own = 0;
        rr     = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        step();
        chk("rst_mmu_req", 32'(obs_mreq), 32'd0);
        chk("rst_p0_aok", 32'(obs_aok[0]), 32'd0);
        chk("rst_p1_aok", 32'(obs_aok[1]), 32'd0);
        chk("rst_p0_dok", 32'(obs_dok[0]), 32'd0);
        chk("rst_p1_dok", 32'(obs_dok[1]), 32'd0);

        // single p0 load
        rq[0] = 1'b1;
        pl[0] = '{addr: 32'h1000, we: 1'b0, size: 2'd2, wstrb: 4'hf, wdata: 32'h0};
        aok   = 1'b1;
        step();
        chk("tp1_p0_aok", 32'(obs_aok[0]), 32'd1);
        chk("tp1_addr", obs_addr, 32'h1000);
        chk("tp1_p1_aok", 32'(obs_aok[1]), 32'd0);
        rq[0] = 1'b0;
        aok   = 1'b0;
        step();
        chk("tp1_c2_p0_aok", 32'(obs_aok[0]), 32'd0);
        dok = 1'b1;
        rd  = 32'hDEADBEEF;
        step();
        chk("tp1_p0_dok", 32'(obs_dok[0]), 32'd1);
        chk("tp1_rdata", obs_rdata, 32'hDEADBEEF);
        chk("tp1_p1_dok", 32'(obs_dok[1]), 32'd0);
        dok = 1'b0;

        // both requesting continuously, grants alternate (p1 first: p0 went last)
        rq  = '{1'b1, 1'b1};
        aok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_p1 = FIXED ? 1'b0 : (i % 2 == 0);
            step();
            chk("tp2_p1_aok", 32'(obs_aok[1]), 32'(exp_p1));
            chk("tp2_p0_aok", 32'(obs_aok[0]), 32'(!exp_p1));
            if (obs_aok[0]) pl[0] = rand_pl();
            if (obs_aok[1]) pl[1] = rand_pl();
        end
        rq  = '{1'b0, 1'b0};
        aok = 1'b0;
        dok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_p1 = FIXED ? 1'b0 : (i % 2 == 0);
            rd = $urandom;
            step();
            chk("tp2_p1_dok", 32'(obs_dok[1]), 32'(exp_p1));
            chk("tp2_p0_dok", 32'(obs_dok[0]), 32'(!exp_p1));
        end
        dok = 1'b0;

        // p1 locked while addr_ok held low, p0 arrives meanwhile
        pl[1] = rand_pl();
        pl[0] = rand_pl();
        rq[1] = 1'b1;
        step();
        chk("tp3_addr0", obs_addr, pl[1].addr);
        rq[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("tp3_addr_hold", obs_addr, pl[1].addr);
        end
        aok = 1'b1;
        step();
        chk("tp3_p1_aok", 32'(obs_aok[1]), 32'd1);
        rq[1] = 1'b0;
        step();
        chk("tp3_p0_aok", 32'(obs_aok[0]), 32'd1);
        rq[0] = 1'b0;
        aok   = 1'b0;
        dok   = 1'b1;
        repeat (2) step();
        dok = 1'b0;

        // fill to MAXO, then gating and same-cycle pop
        rq[0] = 1'b1;
        aok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pl[0] = rand_pl();
            step();
            chk("tp4_fill", 32'(obs_mreq), 32'd1);
        end
        rq[0] = 1'b0;
        rq[1] = 1'b1;
        pl[1] = rand_pl();
        step();
        chk("tp4_full_mreq", 32'(obs_mreq), 32'd0);
        chk("tp4_full_aok", 32'(obs_aok[1]), 32'd0);
        dok = 1'b1;
        step();
        chk("tp4_pop_mreq", 32'(obs_mreq), 32'd1);
        chk("tp4_pop_aok", 32'(obs_aok[1]), 32'd1);
        chk("tp4_pop_dok", 32'(obs_dok[0]), 32'd1);
        dok   = 1'b0;
        pl[1] = rand_pl();
        step();
        chk("tp4_still_full", 32'(obs_mreq), 32'd0);
        rq[1] = 1'b0;
        aok   = 1'b0;
        dok   = 1'b1;
        repeat (4) step();
        dok = 1'b0;

        // withdraw while locked: nothing recorded
        rq[0] = 1'b1;
        pl[0] = rand_pl();
        step();
        rq[0] = 1'b0;
        rq[1] = 1'b1;
        pl[1] = rand_pl();
        aok   = 1'b1;
        step();
        chk("tp5_withdraw_mreq", 32'(obs_mreq), 32'd0);
        step();
        chk("tp5_p1_aok", 32'(obs_aok[1]), 32'd1);
        rq[1] = 1'b0;
        aok   = 1'b0;
        dok   = 1'b1;
        step();
        chk("tp5_head_p1", 32'(obs_dok[1]), 32'd1);
        chk("tp5_no_p0", 32'(obs_dok[0]), 32'd0);
        dok = 1'b0;

        // reset with two outstanding clears ownership
        rq[0] = 1'b1;
        aok   = 1'b1;
        repeat (2) begin
            pl[0] = rand_pl();
            step();
        end
        rq[0] = 1'b0;
        aok   = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("tp6_mreq_idle", 32'(obs_mreq), 32'd0);
        rq[0] = 1'b1;
        aok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pl[0] = rand_pl();
            step();
            chk("tp6_refill", 32'(obs_mreq), 32'd1);
        end
        pl[0] = rand_pl();
        step();
        chk("tp6_full", 32'(obs_mreq), 32'd0);
        rq[0] = 1'b0;
        aok   = 1'b0;
        dok   = 1'b1;
        repeat (4) step();
        dok = 1'b0;

        // randomized traffic with occasional withdrawals
        for (int c = 0; c < 400; c++) begin
            for (int x = 0; x < 2; x++) begin
                if (rq[x] && !obs_aok[x]) begin
                    if ($urandom_range(0, 15) == 0) rq[x] = 1'b0;
                end else begin
                    rq[x] = 1'($urandom_range(0, 1));
                    pl[x] = rand_pl();
                end
            end
            aok = 1'($urandom_range(0, 1));
            dok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            rd  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
